// File: rtl/autoconfig_ctrl_if.sv
// 68000 bus signals seen by the AutoConfig controller: address, data nibble and strobes.
// The CPU side drives the strobes; the board answers on DOUT/DOE.
interface autoconfig_ctrl_if;
  logic [23:1] ADDR;
  logic [3:0]  DIN;
  logic [3:0]  DOUT;
  logic        DOE;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;

  modport master (output ADDR, DIN, AS_n, UDS_n, LDS_n, RW, input DOUT, DOE);
  modport slave  (input ADDR, DIN, AS_n, UDS_n, LDS_n, RW, output DOUT, DOE);
endinterface

// File: rtl/autoconfig_ctrl.sv
// Zorro II AutoConfig controller for the IDE board: serves the config nibbles at $E80000,
// latches the 128 KB base written by the OS and drives CFGOUT_n down the chain.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNCONF    | answering config space at $E80000
// CFG_PEND  | base latched, waiting for the configuring bus cycle to end
// SHUT_PEND | shut-up written, waiting for the bus cycle to end
// CONFIG    | base valid, board decodes its 128 KB window
// SHUTUP    | board told to stay off the bus
module autoconfig_ctrl #(
  parameter logic [15:0] MANUF_ID = 16'h082C,
  parameter logic [7:0]  PROD_ID  = 8'h07,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [7:0]  ER_TYPE  = 8'hD2,
  parameter logic [15:0] ROM_VEC  = 16'h0010
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  autoconfig_ctrl_if.slave        bus,
  input  logic                    CFGIN_n,
  output logic                    CFGOUT_n,
  input  logic                    ENABLE,
  output logic                    ide_access,
  output logic                    configured
);

  typedef enum logic [2:0] {UNCONF, CFG_PEND, SHUT_PEND, CONFIG, SHUTUP} state_t;

  state_t       state, state_nxt;
  logic [23:17] base;
  logic         wr_done;
  logic         cfg_sel;
  logic         wr_cap;
  logic [3:0]   rom_nib;
  logic         unused_ok;

  // RESET_n in the select keeps DOE quiet while reset is held with AS_n low
  assign cfg_sel = RESET_n && ENABLE && !CFGIN_n && !bus.AS_n &&
                   (bus.ADDR[23:16] == 8'hE8) && (state == UNCONF);
  assign wr_cap  = cfg_sel && !bus.RW && !bus.UDS_n && !wr_done;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= UNCONF;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNCONF: begin
        if (wr_cap && bus.ADDR[7:1] == 7'h24)      state_nxt = CFG_PEND;
        else if (wr_cap && bus.ADDR[7:1] == 7'h26) state_nxt = SHUT_PEND;
      end
      CFG_PEND:  if (bus.AS_n) state_nxt = CONFIG;
      SHUT_PEND: if (bus.AS_n) state_nxt = SHUTUP;
      default:   state_nxt = state;
    endcase
    if (!ENABLE) state_nxt = UNCONF;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      base    <= '0;
      wr_done <= 1'b0;
    end else if (bus.AS_n) begin
      wr_done <= 1'b0;
    end else if (wr_cap) begin
      wr_done <= 1'b1;
      case (bus.ADDR[7:1])
        7'h25:   base[19:17] <= bus.DIN[3:1];
        7'h24:   base[23:20] <= bus.DIN;
        default: ;
      endcase
    end
  end

  // Everything but er_Type and the $40 control nibbles is stored inverted on the bus
  always_comb begin
    rom_nib = 4'hF;
    case (bus.ADDR[7:1])
      7'h00: rom_nib = ER_TYPE[7:4];
      7'h01: rom_nib = ER_TYPE[3:0];
      7'h02: rom_nib = ~PROD_ID[7:4];
      7'h03: rom_nib = ~PROD_ID[3:0];
      7'h04, 7'h05: rom_nib = 4'hF;
      7'h08: rom_nib = ~MANUF_ID[15:12];
      7'h09: rom_nib = ~MANUF_ID[11:8];
      7'h0A: rom_nib = ~MANUF_ID[7:4];
      7'h0B: rom_nib = ~MANUF_ID[3:0];
      7'h0C: rom_nib = ~SERIAL[31:28];
      7'h0D: rom_nib = ~SERIAL[27:24];
      7'h0E: rom_nib = ~SERIAL[23:20];
      7'h0F: rom_nib = ~SERIAL[19:16];
      7'h10: rom_nib = ~SERIAL[15:12];
      7'h11: rom_nib = ~SERIAL[11:8];
      7'h12: rom_nib = ~SERIAL[7:4];
      7'h13: rom_nib = ~SERIAL[3:0];
      7'h14: rom_nib = ~ROM_VEC[15:12];
      7'h15: rom_nib = ~ROM_VEC[11:8];
      7'h16: rom_nib = ~ROM_VEC[7:4];
      7'h17: rom_nib = ~ROM_VEC[3:0];
      7'h20, 7'h21: rom_nib = 4'h0;
      default: rom_nib = 4'hF;
    endcase
  end

  assign bus.DOE  = cfg_sel && bus.RW;
  assign bus.DOUT = bus.DOE ? rom_nib : 4'hF;

  assign configured = (state == CONFIG);
  assign CFGOUT_n   = ENABLE ? !((state == CONFIG) || (state == SHUTUP)) : CFGIN_n;
  assign ide_access = configured && !bus.AS_n && (bus.ADDR[23:17] == base);

  assign unused_ok  = ^{bus.LDS_n, bus.ADDR[15:8], bus.DIN[0]};

endmodule

// File: tb/tb_autoconfig_ctrl.sv
// Self-checking bench for autoconfig_ctrl: behavioural AutoConfig model compared every cycle,
// directed checks from the bring-up sequence, then randomized bus traffic.
module tb_autoconfig_ctrl;
  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  logic CFGIN_n = 1'b0;
  logic ENABLE = 1'b1;
  logic CFGOUT_n, ide_access, configured;

  autoconfig_ctrl_if bus();

  autoconfig_ctrl dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus), .CFGIN_n(CFGIN_n), .CFGOUT_n(CFGOUT_n),
    .ENABLE(ENABLE), .ide_access(ide_access), .configured(configured)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_OPEN = 0, M_PEND_CFG = 1, M_PEND_SHUT = 2, M_CFG = 3, M_SHUT = 4;
  logic [3:0] rom [0:127];
  int         m_mode = M_OPEN;
  logic [6:0] m_base = '0;
  bit         m_wr_done = 1'b0;

  // byte k of a field lives at offsets off+4k (high nibble) and off+4k+2 (low nibble)
  task automatic put_field(input int off, input int nbytes, input logic [31:0] val, input bit inv);
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] byt;
      byt = val[8*(nbytes-1-b) +: 8];
      if (inv) byt = ~byt;
      rom[(off + 4*b) / 2]     = byt[7:4];
      rom[(off + 4*b) / 2 + 1] = byt[3:0];
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 4'hF;
    put_field('h00, 1, 32'hD2, 0);
    put_field('h04, 1, 32'h07, 1);
    put_field('h08, 1, 32'h00, 1);
    put_field('h10, 2, 32'h082C, 1);
    put_field('h18, 4, 32'h00000001, 1);
    put_field('h28, 2, 32'h0010, 1);
    put_field('h40, 1, 32'h00, 0);
  end

  function automatic bit model_sel();
    return RESET_n && ENABLE && !CFGIN_n && !bus.AS_n && (bus.ADDR[23:16] == 8'hE8) &&
           (m_mode == M_OPEN);
  endfunction

  always @(negedge RESET_n) begin
    m_mode = M_OPEN; m_base = '0; m_wr_done = 1'b0;
  end

  always @(posedge CLK) begin
    if (!RESET_n) begin
      m_mode = M_OPEN; m_base = '0; m_wr_done = 1'b0;
    end else begin
      bit sel;
      int nm;
      int off;
      sel = model_sel();
      nm  = m_mode;
      off = int'(bus.ADDR[7:1]) * 2;
      if (m_mode == M_PEND_CFG  && bus.AS_n) nm = M_CFG;
      if (m_mode == M_PEND_SHUT && bus.AS_n) nm = M_SHUT;
      if (bus.AS_n) m_wr_done = 1'b0;
      else if (sel && !bus.RW && !bus.UDS_n && !m_wr_done) begin
        m_wr_done = 1'b1;
        if (off == 'h4A) m_base[2:0] = bus.DIN[3:1];
        else if (off == 'h48) begin m_base[6:3] = bus.DIN; nm = M_PEND_CFG; end
        else if (off == 'h4C) nm = M_PEND_SHUT;
      end
      if (!ENABLE) nm = M_OPEN;
      m_mode = nm;
    end
  end

  always @(negedge CLK) begin
    bit sel, e_doe, e_conf, e_cfgout, e_ide;
    logic [3:0] e_dout;
    sel      = model_sel();
    e_doe    = sel && bus.RW;
    e_dout   = e_doe ? rom[bus.ADDR[7:1]] : 4'hF;
    e_conf   = (m_mode == M_CFG);
    e_cfgout = ENABLE ? !(m_mode == M_CFG || m_mode == M_SHUT) : CFGIN_n;
    e_ide    = e_conf && !bus.AS_n && (bus.ADDR[23:17] == m_base);
    chk("cyc_DOE", bus.DOE, e_doe);
    chk("cyc_DOUT", bus.DOUT, e_dout);
    chk("cyc_configured", configured, e_conf);
    chk("cyc_CFGOUT_n", CFGOUT_n, e_cfgout);
    chk("cyc_ide_access", ide_access, e_ide);
  end

  // ---------------- bus cycle helpers ----------------
  task automatic bus_cycle(input logic [23:0] ba, input logic rw, input logic [3:0] din,
                           input logic uds, input logic lds,
                           output logic [3:0] dout, output logic doe, output logic ide);
    @(posedge CLK); #2;
    bus.ADDR = ba[23:1]; bus.RW = rw; bus.DIN = din;
    bus.AS_n = 1'b0; bus.UDS_n = uds; bus.LDS_n = lds;
    @(negedge CLK);
    dout = bus.DOUT; doe = bus.DOE; ide = ide_access;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW = 1'b1;
  endtask

  logic [3:0] s_dout;
  logic       s_doe, s_ide;

  task automatic rd(input logic [23:0] ba);
    bus_cycle(ba, 1'b1, 4'hF, 1'b0, 1'b0, s_dout, s_doe, s_ide);
  endtask

  task automatic wr(input logic [23:0] ba, input logic [3:0] din, input logic uds);
    bus_cycle(ba, 1'b0, din, uds, 1'b0, s_dout, s_doe, s_ide);
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #2 RESET_n = 1'b0;
    @(posedge CLK); #2 RESET_n = 1'b1;
  endtask

  initial begin
    logic [23:0] ba;
    bus.ADDR = '0; bus.DIN = 4'hF; bus.AS_n = 1'b1; bus.UDS_n = 1'b1;
    bus.LDS_n = 1'b1; bus.RW = 1'b1;
    #3;
    chk("rst_CFGOUT_n", CFGOUT_n, 1'b1);
    chk("rst_configured", configured, 1'b0);
    chk("rst_DOE", bus.DOE, 1'b0);
    chk("rst_DOUT", bus.DOUT, 4'hF);
    chk("rst_ide", ide_access, 1'b0);
    bus.ADDR = 23'h740000; bus.AS_n = 1'b0;
    #1 chk("rst_DOE_in_cfg_space", bus.DOE, 1'b0);
    bus.AS_n = 1'b1;
    @(posedge CLK); #2 RESET_n = 1'b1;

    rd(24'hE80000); chk("rd00_DOE", s_doe, 1'b1); chk("rd00", s_dout, 4'hD);
    rd(24'hE80002); chk("rd02", s_dout, 4'h2);
    rd(24'hE80010); chk("rd10", s_dout, 4'hF);
    rd(24'hE80012); chk("rd12", s_dout, 4'h7);
    rd(24'hE80040); chk("rd40", s_dout, 4'h0);
    rd(24'hE80044); chk("rd44_undef", s_dout, 4'hF);
    rd(24'hE80026); chk("rd26_serial_lsn", s_dout, 4'hE);

    wr(24'hE8004A, 4'hA, 1'b0);
    wr(24'hE80048, 4'hE, 1'b0);
    chk("pend_CFGOUT_n", CFGOUT_n, 1'b1);
    chk("pend_configured", configured, 1'b0);
    @(posedge CLK); #1;
    chk("cfg_CFGOUT_n", CFGOUT_n, 1'b0);
    chk("cfg_configured", configured, 1'b1);
    rd(24'hEA0000); chk("ide_EA0000", s_ide, 1'b1);
    rd(24'hE80000); chk("cfg_no_DOE", s_doe, 1'b0);
    rd(24'hEBFFFE); chk("ide_EBFFFE", s_ide, 1'b1);
    rd(24'hEC0000); chk("ide_EC0000", s_ide, 1'b0);
    rd(24'hE9FFFE); chk("ide_E9FFFE", s_ide, 1'b0);

    pulse_reset();
    bus_cycle(24'hE80048, 1'b0, 4'hE, 1'b1, 1'b0, s_dout, s_doe, s_ide);
    rd(24'hE80000); chk("lds_only_ignored", s_dout, 4'hD);
    wr(24'hE8004C, 4'h0, 1'b0);
    @(posedge CLK); #1;
    chk("shut_CFGOUT_n", CFGOUT_n, 1'b0);
    chk("shut_configured", configured, 1'b0);
    for (int i = 0; i < 12; i++) begin
      ba = (i < 4) ? 24'h000000 + 24'(i) * 24'h20000 : 24'($urandom);
      rd(ba);
      chk("shut_no_ide", s_ide, 1'b0);
    end

    pulse_reset();
    ENABLE = 1'b0;
    CFGIN_n = 1'b1; #1 chk("pass_hi", CFGOUT_n, 1'b1);
    CFGIN_n = 1'b0; #1 chk("pass_lo", CFGOUT_n, 1'b0);
    CFGIN_n = 1'b1; #1 chk("pass_hi2", CFGOUT_n, 1'b1);
    CFGIN_n = 1'b0;
    rd(24'hE80000); chk("disabled_DOE", s_doe, 1'b0);
    ENABLE = 1'b1;

    pulse_reset();
    wr(24'hE8004A, 4'h2, 1'b0);
    @(posedge CLK); #2;
    bus.ADDR = 23'h740024; bus.RW = 1'b0; bus.DIN = 4'h3; bus.AS_n = 1'b0; bus.UDS_n = 1'b0;
    @(posedge CLK); #2 RESET_n = 1'b0;
    #1;
    chk("midrst_CFGOUT_n", CFGOUT_n, 1'b1);
    chk("midrst_configured", configured, 1'b0);
    chk("midrst_DOE", bus.DOE, 1'b0);
    @(posedge CLK); #2;
    bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.RW = 1'b1; RESET_n = 1'b1;
    rd(24'hE80000); chk("midrst_rd00", s_dout, 4'hD);

    for (int n = 0; n < 700; n++) begin
      int pick;
      logic [7:0] off;
      pick = int'($urandom_range(0, 9));
      if (pick < 5) begin
        case ($urandom_range(0, 7))
          0: off = 8'h48;
          1: off = 8'h4A;
          2: off = 8'h4C;
          3: off = 8'h00;
          default: off = {1'b0, 6'($urandom), 1'b0};
        endcase
        ba = {16'hE800, off};
      end else if (pick < 8) ba = {m_base, 17'($urandom)};
      else ba = 24'($urandom);
      ba[0] = 1'b0;
      CFGIN_n = ($urandom_range(0, 9) == 0);
      ENABLE  = ($urandom_range(0, 19) != 0);
      bus_cycle(ba, 1'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0),
                1'($urandom), s_dout, s_doe, s_ide);
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    @(posedge CLK); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
